mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one unified, variable-latency memory port between two requesters of the CPU datapath: instruction fetch (port 0) and data load/store (port 1).
- Arbitrates between them with round-robin and latches the winning request.
- Sequences the memory handshake until `mem_ready` arrives, then returns the read data with a one-cycle done pulse.
- A programmable watchdog aborts hung transactions and flags an error.

Parameters:
- ADDR_W, 64, address width of both requesters and the memory port.
- DATA_W, 64, data width of read and write paths.
- TIMEOUT, 255, maximum BUSY cycles waiting for mem_ready. 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset. 0 = in reset.
- if_req  input  1  fetch request. Held until if_done.
- if_addr  input  ADDR_W  fetch address. Stable while if_req=1.
- if_done  output  1  one-cycle completion pulse for a fetch.
- if_rdata  output  DATA_W  fetched word. Registered, holds until the next fetch completes.
- d_req  input  1  data request. Held until d_done.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_done  output  1  one-cycle completion pulse for a data access.
- d_rdata  output  DATA_W  load data. Registered.
- err  output  1  pulses together with if_done/d_done when the transaction timed out.
- busy  output  1  1 when the FSM is not in IDLE.
- grant_id  output  1  owner of the current or last transaction: 0 = fetch, 1 = data.
- mem_req  output  1  memory request. Registered.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  latched address.
- mem_wdata  output  DATA_W  latched write data.
- mem_rdata  input  DATA_W  memory read data. Valid when mem_ready=1.
- mem_ready  input  1  memory completion. Honoured only in BUSY.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state = IDLE; every output = 0 (mem_req, mem_we, mem_addr, mem_wdata, if_done, d_done, if_rdata, d_rdata, err, busy, grant_id);
  - last_gnt = 0, so data wins the first tie;
  - watchdog counter = 0.
  - Reset mid-transaction drops mem_req immediately without a clock edge. The aborted transaction produces no done.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - No request: remain in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the port that is not last_gnt.
  - On a grant, at the clock edge:
    - latch addr into mem_addr;
    - latch we (fetch forces 0) and wdata (fetch forces 0);
    - set grant_id and last_gnt to the winner;
    - set mem_req=1, clear the counter, go to BUSY.
- BUSY:
  - mem_req, mem_we, mem_addr and mem_wdata are held constant.
  - Counter increments each cycle.
  - mem_ready=1:
    - if the access is a read, capture mem_rdata into the winner's rdata register;
    - mem_req→0; go to RESP with err=0.
  - Otherwise, if TIMEOUT≠0 and counter==TIMEOUT-1:
    - mem_req→0; go to RESP with err=1;
    - if the access is a read, the winner's rdata register is set to 0.
  - If mem_ready=1 arrives in the timeout cycle, mem_ready takes priority (success, not error).
- RESP:
  - Exactly one cycle.
  - Winner's done=1; err as decided in BUSY; mem_req=0.
  - Next state: IDLE.
- Stores never modify d_rdata.
- Requester protocol:
  - req, addr, we and wdata stay stable from assertion until the done cycle.
  - req still high in the IDLE cycle after done is a new request.
- Latency:
  - Request seen in IDLE at cycle 0 → mem_req high from cycle 1.
  - mem_ready sampled in cycle k → done in cycle k+1.
  - Minimum is done in cycle 2, then one IDLE cycle before the next grant.
  - Back-to-back throughput is 3 cycles per access at zero memory wait.
- Other rules:
  - mem_ready outside BUSY is ignored.
  - No starvation: under continuous contention, grants strictly alternate.
  - Counter width is $clog2(TIMEOUT+1), minimum 1.
  - busy = (state≠IDLE).

Test Plan:
1. Reset: drive reset=0 with mem_ready=1 and both reqs high → all outputs 0. Release reset → first grant goes to data (grant_id=1).
2. Single fetch: if_req=1, if_addr=0x40, mem_ready=1 in the first BUSY cycle, mem_rdata=0xDEADBEEF → mem_req=1 in cycle 1 with mem_addr=0x40 and mem_we=0; if_done pulses in cycle 2; if_rdata=0xDEADBEEF; err=0.
3. Contention: both reqs held for 6 transactions, memory ready after 2 cycles → grant order is data, fetch, data, fetch, data, fetch; each done pulse lasts exactly one cycle.
4. Store: d_we=1, d_addr=0x100, d_wdata=0x1234, with d_rdata previously 0x55 → mem_we=1 and mem_wdata=0x1234 during BUSY; d_done pulses; d_rdata stays 0x55.
5. Timeout: TIMEOUT=4, mem_ready held 0 on a load → mem_req high exactly 4 cycles; then d_done=1 and err=1 in the same cycle; d_rdata=0. Repeat with mem_ready=1 in the 4th BUSY cycle → err=0 and data captured.
6. Reset mid-BUSY: assert reset between clock edges → mem_req falls immediately. After release, a late mem_ready=1 produces no done and the FSM stays in IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between the
// instruction fetch requester (port 0) and the data load/store requester
// (port 1). Conflicts are resolved round-robin. The winning request is
// latched and presented to memory until mem_ready arrives. A programmable
// watchdog aborts a transaction that hangs and reports it through err.

module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,

    output logic              err,
    output logic              busy,
    output logic              grant_id,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    // The watchdog counter must reach TIMEOUT-1. It keeps at least one bit
    // so the design still elaborates when the watchdog is disabled.
    localparam int CNT_RAW = $clog2(TIMEOUT + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             last_gnt;
    logic [CNT_W-1:0] wd_cnt;

    logic             pick_data;
    logic             timeout_hit;

    // Data wins when it is the only requester, or when both request and
    // fetch owned the previous grant. The two ports therefore alternate
    // under continuous contention.
    assign pick_data   = d_req && (!if_req || !last_gnt);

    // The watchdog fires in the last permitted BUSY cycle. A zero TIMEOUT
    // disables it.
    assign timeout_hit = (TIMEOUT != 0) && (wd_cnt == CNT_LAST);

    // The owner of the current or last transaction is the round-robin pointer.
    assign grant_id    = last_gnt;
    assign busy        = (state != IDLE);

    // Main sequencer: grant in IDLE, hold the memory request in BUSY, pulse done in RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last_gnt  <= 1'b0;
            wd_cnt    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            err       <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            err     <= 1'b0;

            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        mem_addr  <= pick_data ? d_addr : if_addr;
                        mem_we    <= pick_data & d_we;
                        mem_wdata <= pick_data ? d_wdata : '0;
                        last_gnt  <= pick_data;
                        mem_req   <= 1'b1;
                        wd_cnt    <= '0;
                        state     <= BUSY;
                    end
                end

                BUSY: begin
                    wd_cnt <= wd_cnt + CNT_W'(1);
                    if (mem_ready) begin
                        if (!mem_we) begin
                            if (last_gnt) begin
                                d_rdata <= mem_rdata;
                            end else begin
                                if_rdata <= mem_rdata;
                            end
                        end
                        mem_req <= 1'b0;
                        if_done <= !last_gnt;
                        d_done  <= last_gnt;
                        err     <= 1'b0;
                        state   <= RESP;
                    end else if (timeout_hit) begin
                        if (!mem_we) begin
                            if (last_gnt) begin
                                d_rdata <= '0;
                            end else begin
                                if_rdata <= '0;
                            end
                        end
                        mem_req <= 1'b0;
                        if_done <= !last_gnt;
                        d_done  <= last_gnt;
                        err     <= 1'b1;
                        state   <= RESP;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: drives both requesters and a memory with random
// latency. Every completed transaction is compared against a transaction-level
// model of round-robin arbitration, watchdog expiry and read-data capture.

module tb_mem_port_arbiter;

    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              err;
    logic              busy;
    logic              grant_id;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: port owning the last grant, and the expected read registers.
    bit          model_last;
    logic [63:0] exp_if_rdata;
    logic [63:0] exp_d_rdata;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .err      (err),
        .busy     (busy),
        .grant_id (grant_id),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever loses track of the DUT.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs are driven and outputs sampled 1 ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic raiseFetch();
        if_req  = 1'b1;
        if_addr = rand64();
    endtask

    task automatic raiseData();
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = rand64();
        d_wdata = rand64();
    endtask

    // Called in an IDLE cycle: any idle port may start a new request, and at least one request is pending.
    task automatic applyStimulus();
        if (!if_req && $urandom_range(0, 1) == 1) raiseFetch();
        if (!d_req && $urandom_range(0, 1) == 1) raiseData();
        if (!if_req && !d_req) begin
            if ($urandom_range(0, 1) == 1) raiseFetch();
            else raiseData();
        end
    endtask

    // Runs one transaction from an IDLE cycle with requests already driven.
    // The memory answers after wait_cyc BUSY cycles, or never if the watchdog expires first.
    task automatic runTransaction(input int wait_cyc, input logic [63:0] ready_data, input bit keep_winner);
        bit          w;
        bit          e_we;
        bit          e_err;
        logic [63:0] e_addr;
        logic [63:0] e_wdata;
        int          n;
        int          e_n;

        w          = (if_req && d_req) ? !model_last : d_req;
        model_last = w;
        e_addr     = w ? d_addr : if_addr;
        e_we       = w ? d_we : 1'b0;
        e_wdata    = w ? d_wdata : 64'd0;

        checkOutput("idle_busy", 64'(busy), 64'd0);
        checkOutput("idle_mem_req", 64'(mem_req), 64'd0);
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = rand64();
        step();

        n = 0;
        while (mem_req === 1'b1 && n < 20) begin
            checkOutput("busy_mem_addr", mem_addr, e_addr);
            checkOutput("busy_mem_we", 64'(mem_we), 64'(e_we));
            checkOutput("busy_mem_wdata", mem_wdata, e_wdata);
            checkOutput("busy_grant_id", 64'(grant_id), 64'(w));
            checkOutput("busy_flag", 64'(busy), 64'd1);
            checkOutput("busy_no_done", 64'({if_done, d_done, err}), 64'd0);
            mem_ready = (n == wait_cyc);
            mem_rdata = (n == wait_cyc) ? ready_data : rand64();
            n++;
            step();
        end

        e_err = (wait_cyc >= TIMEOUT);
        e_n   = e_err ? TIMEOUT : wait_cyc + 1;
        checkOutput("req_cycles", 64'(n), 64'(e_n));

        if (!e_we) begin
            if (w) exp_d_rdata = e_err ? 64'd0 : ready_data;
            else exp_if_rdata = e_err ? 64'd0 : ready_data;
        end

        checkOutput("resp_if_done", 64'(if_done), 64'(!w));
        checkOutput("resp_d_done", 64'(d_done), 64'(w));
        checkOutput("resp_err", 64'(err), 64'(e_err));
        checkOutput("resp_busy", 64'(busy), 64'd1);
        checkOutput("resp_mem_req", 64'(mem_req), 64'd0);
        checkOutput("resp_grant_id", 64'(grant_id), 64'(w));
        checkOutput("if_rdata", if_rdata, exp_if_rdata);
        checkOutput("d_rdata", d_rdata, exp_d_rdata);

        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = rand64();
        if (w) begin
            if (keep_winner) raiseData();
            else d_req = 1'b0;
        end else begin
            if (keep_winner) raiseFetch();
            else if_req = 1'b0;
        end
        step();

        checkOutput("idle_after_done", 64'({if_done, d_done, err}), 64'd0);
        checkOutput("idle_after_busy", 64'(busy), 64'd0);
    endtask

    // Directed scenarios first, then random traffic, then the mid-transaction reset.
    initial begin
        int guard;

        reset     = 1'b0;
        if_req    = 1'b1;
        if_addr   = 64'h40;
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = rand64();
        d_wdata   = rand64();
        mem_ready = 1'b1;
        mem_rdata = rand64();
        model_last   = 1'b0;
        exp_if_rdata = 64'd0;
        exp_d_rdata  = 64'd0;
        #1;
        repeat (3) step();

        checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
        checkOutput("rst_mem_we", 64'(mem_we), 64'd0);
        checkOutput("rst_mem_addr", mem_addr, 64'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 64'd0);
        checkOutput("rst_dones", 64'({if_done, d_done}), 64'd0);
        checkOutput("rst_if_rdata", if_rdata, 64'd0);
        checkOutput("rst_d_rdata", d_rdata, 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_grant_id", 64'(grant_id), 64'd0);

        reset = 1'b1;
        runTransaction($urandom_range(0, 3), rand64(), 1'b0);
        checkOutput("first_grant_data", 64'(grant_id), 64'd1);

        runTransaction(0, 64'hDEADBEEF, 1'b0);
        checkOutput("fetch_rdata", if_rdata, 64'hDEADBEEF);

        for (int i = 0; i < 150; i++) begin
            applyStimulus();
            runTransaction($urandom_range(0, 6), rand64(), 1'($urandom_range(0, 1)));
        end

        guard = 0;
        while ((if_req || d_req) && guard < 4) begin
            runTransaction($urandom_range(0, 2), rand64(), 1'b0);
            guard++;
        end
        checkOutput("drained", 64'({if_req, d_req}), 64'd0);

        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = rand64();
        d_wdata = rand64();
        runTransaction(0, 64'h55, 1'b0);
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 64'h100;
        d_wdata = 64'h1234;
        runTransaction(1, rand64(), 1'b0);
        checkOutput("store_keeps_rdata", d_rdata, 64'h55);

        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = rand64();
        runTransaction(20, rand64(), 1'b0);
        checkOutput("timeout_rdata", d_rdata, 64'd0);
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = rand64();
        runTransaction(TIMEOUT - 1, 64'hCAFE, 1'b0);
        checkOutput("late_ready_rdata", d_rdata, 64'hCAFE);

        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = rand64();
        mem_ready = 1'b0;
        step();
        checkOutput("pre_reset_mem_req", 64'(mem_req), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_mem_req", 64'(mem_req), 64'd0);
        checkOutput("async_reset_busy", 64'(busy), 64'd0);
        d_req     = 1'b0;
        if_req    = 1'b0;
        mem_ready = 1'b1;
        step();
        reset        = 1'b1;
        model_last   = 1'b0;
        exp_if_rdata = 64'd0;
        exp_d_rdata  = 64'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("post_reset_no_done", 64'({if_done, d_done, err}), 64'd0);
            checkOutput("post_reset_idle", 64'({busy, mem_req}), 64'd0);
        end

        raiseFetch();
        raiseData();
        runTransaction($urandom_range(0, 3), rand64(), 1'b0);
        runTransaction($urandom_range(0, 3), rand64(), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
